// File: rtl/color_dwell_logger.sv
// rtl/color_dwell_logger.sv - measures colour dwell lengths and queues one record per completed dwell
module color_dwell_logger #(
  parameter int DWELL_WIDTH = 8,
  parameter int DEPTH       = 4,
  parameter int DROP_WIDTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               color,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic                     rec_color,
  output logic [DWELL_WIDTH-1:0]   rec_dwell,
  output logic                     rec_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DROP_WIDTH-1:0]    drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  state_t                 state, state_d;
  logic                   cur, cur_d;
  logic [DWELL_WIDTH-1:0] dwell, dwell_d;
  logic                   code_ok, code_red;
  logic                   push, push_err;

  assign code_ok  = (color == 2'h1) || (color == 2'h2);
  assign code_red = (color == 2'h2);

  always_comb begin
    state_d  = state;
    cur_d    = cur;
    dwell_d  = dwell;
    push     = 1'b0;
    push_err = 1'b0;
    case (state)
      IDLE, FAULT: begin
        if (code_ok) begin
          state_d = TRACK;
          cur_d   = code_red;
          dwell_d = DWELL_WIDTH'(1);
        end
      end
      TRACK: begin
        if (!code_ok) begin
          push     = 1'b1;
          push_err = 1'b1;
          state_d  = FAULT;
        end else if (code_red == cur) begin
          if (dwell != '1) dwell_d = dwell + DWELL_WIDTH'(1);
        end else begin
          push    = 1'b1;
          cur_d   = code_red;
          dwell_d = DWELL_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Record FIFO; the pushed record is the dwell that just ended (cur/dwell before update)
  logic                   mem_color [DEPTH];
  logic [DWELL_WIDTH-1:0] mem_dwell [DEPTH];
  logic                   mem_err   [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   pop, full, wr_en, drop;

  assign pop   = rec_valid && rec_ready;
  assign full  = (count == FULL_LVL);
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= 1'b0;
      dwell    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_d;
      cur   <= cur_d;
      dwell <= dwell_d;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      count <= count + (AW+1)'(1);
      else if (!wr_en && pop) count <= count - (AW+1)'(1);
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_color[wr_ptr] <= cur;
      mem_dwell[wr_ptr] <= dwell;
      mem_err[wr_ptr]   <= push_err;
    end
  end

  assign rec_valid = (count != '0);
  assign level     = count;
  assign rec_color = rec_valid ? mem_color[rd_ptr] : 1'b0;
  assign rec_dwell = rec_valid ? mem_dwell[rd_ptr] : '0;
  assign rec_err   = rec_valid ? mem_err[rd_ptr]   : 1'b0;

endmodule

// File: tb/tb_color_dwell_logger.sv
// tb/tb_color_dwell_logger.sv - scoreboard bench for color_dwell_logger
module tb_color_dwell_logger;

  logic       clk;
  logic       rst;
  logic [1:0] color;
  logic       rec_valid;
  logic       rec_ready;
  logic       rec_color;
  logic [7:0] rec_dwell;
  logic       rec_err;
  logic [2:0] level;
  logic [3:0] drop_cnt;

  color_dwell_logger #(.DWELL_WIDTH(8), .DEPTH(4), .DROP_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .color(color),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_color(rec_color), .rec_dwell(rec_dwell), .rec_err(rec_err),
    .level(level), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic       c;
    logic [7:0] d;
    logic       e;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_rec(input logic c, input int d, input logic e);
    rec_t r;
    r.c = c;
    r.d = 8'(d);
    r.e = e;
    exp_q.push_back(r);
  endtask

  task automatic cyc(input logic [1:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      color = c;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    color     = 2'h0;
    rec_ready = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 50;
    rec_ready = 1'b1;
    while (level != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    rec_ready = 1'b0;
    chk({name, "_drain_done"}, int'(level), 0);
    chk({name, "_all_delivered"}, exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks head stability under stall
  logic       hold_prev = 1'b0;
  logic       hold_c;
  logic [7:0] hold_d;
  logic       hold_e;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev && rec_valid) begin
        chk("head_stable_color", int'(rec_color), int'(hold_c));
        chk("head_stable_dwell", int'(rec_dwell), int'(hold_d));
        chk("head_stable_err",   int'(rec_err),   int'(hold_e));
      end
      if (rec_valid && rec_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_record: got color=%0d dwell=%0d err=%0d expected none",
                   rec_color, rec_dwell, rec_err);
        end else begin
          rec_t r;
          r = exp_q.pop_front();
          chk("rec_color", int'(rec_color), int'(r.c));
          chk("rec_dwell", int'(rec_dwell), int'(r.d));
          chk("rec_err",   int'(rec_err),   int'(r.e));
        end
      end
      hold_prev <= rec_valid && !rec_ready;
      hold_c    <= rec_color;
      hold_d    <= rec_dwell;
      hold_e    <= rec_err;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    color     = 2'h0;
    rec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_valid", int'(rec_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_drop",  int'(drop_cnt), 0);
    chk("rst_color", int'(rec_color), 0);
    chk("rst_dwell", int'(rec_dwell), 0);
    chk("rst_err",   int'(rec_err), 0);

    // 1: Blue x3 then Red
    cyc(2'h1, 3);
    chk("t1_valid_before", int'(rec_valid), 0);
    expect_rec(1'b0, 3, 1'b0);
    cyc(2'h2, 1);
    chk("t1_valid_after", int'(rec_valid), 1);
    chk("t1_level", int'(level), 1);
    drain("t1");

    // 2: dwell saturation
    do_reset();
    cyc(2'h1, 300);
    chk("t2_no_record", int'(rec_valid), 0);
    expect_rec(1'b0, 255, 1'b0);
    cyc(2'h2, 1);
    drain("t2");

    // 3: overflow with five records, one dropped
    do_reset();
    cyc(2'h1, 2);
    expect_rec(1'b0, 2, 1'b0); cyc(2'h2, 3);
    expect_rec(1'b1, 3, 1'b0); cyc(2'h1, 1);
    expect_rec(1'b0, 1, 1'b0); cyc(2'h2, 4);
    expect_rec(1'b1, 4, 1'b0); cyc(2'h1, 2);
    cyc(2'h2, 1);
    chk("t3_level", int'(level), 4);
    chk("t3_drop",  int'(drop_cnt), 1);
    drain("t3");
    chk("t3_drop_after", int'(drop_cnt), 1);

    // 4: push and pop together while full
    do_reset();
    cyc(2'h1, 1);
    expect_rec(1'b0, 1, 1'b0); cyc(2'h2, 1);
    expect_rec(1'b1, 1, 1'b0); cyc(2'h1, 1);
    expect_rec(1'b0, 1, 1'b0); cyc(2'h2, 1);
    expect_rec(1'b1, 1, 1'b0); cyc(2'h1, 1);
    chk("t4_full", int'(level), 4);
    expect_rec(1'b0, 1, 1'b0);
    rec_ready = 1'b1;
    cyc(2'h2, 1);
    rec_ready = 1'b0;
    chk("t4_level", int'(level), 4);
    chk("t4_drop",  int'(drop_cnt), 0);
    drain("t4");

    // 5: fault interval
    do_reset();
    cyc(2'h2, 2);
    expect_rec(1'b1, 2, 1'b1);
    cyc(2'h0, 2);
    cyc(2'h1, 3);
    chk("t5_one_record", int'(level), 1);
    expect_rec(1'b0, 3, 1'b0);
    cyc(2'h2, 1);
    chk("t5_two_records", int'(level), 2);
    drain("t5");

    // 6: reset with a partly full FIFO and nonzero drop count
    do_reset();
    cyc(2'h1, 1);
    expect_rec(1'b0, 1, 1'b0); cyc(2'h2, 1);
    expect_rec(1'b1, 1, 1'b0); cyc(2'h1, 1);
    expect_rec(1'b0, 1, 1'b0); cyc(2'h2, 1);
    expect_rec(1'b1, 1, 1'b0); cyc(2'h1, 1);
    cyc(2'h2, 1);
    cyc(2'h1, 1);
    chk("t6_drop2", int'(drop_cnt), 2);
    rec_ready = 1'b1;
    cyc(2'h1, 1);
    rec_ready = 1'b0;
    chk("t6_level3", int'(level), 3);
    rst = 1'b1;
    cyc(2'h1, 1);
    exp_q.delete();
    chk("t6_valid", int'(rec_valid), 0);
    chk("t6_level", int'(level), 0);
    chk("t6_drop",  int'(drop_cnt), 0);
    chk("t6_color", int'(rec_color), 0);
    chk("t6_dwell", int'(rec_dwell), 0);
    chk("t6_err",   int'(rec_err), 0);
    rst = 1'b0;
    cyc(2'h1, 2);
    expect_rec(1'b0, 2, 1'b1);
    cyc(2'h0, 1);
    chk("t6_post_level", int'(level), 1);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
